// File: rtl/rename_reg_file_pkg.sv
// Shared defaults and types for the rename register file.
// Latency: n/a (declarations only).
// Backpressure: n/a; the design stalls solely through the global rdy enable.
package rename_reg_file_pkg;

  // Default widths; ROB tags must be wide enough to name every ROB entry.
  localparam int XLEN_DEF     = 32;
  localparam int REG_LOG_DEF  = 5;
  localparam int ROB_LOG_DEF  = 4;
  localparam int NUM_READ_DEF = 2;

  // Where a lookup's result comes from this cycle.
  typedef enum logic [1:0] {
    SRC_NONE    = 2'd0,  // no request on this port
    SRC_ARRAY   = 2'd1,  // architectural value is current
    SRC_BYPASS  = 2'd2,  // producer retires this very cycle
    SRC_PENDING = 2'd3   // still in flight, hand back the ROB tag
  } rd_src_e;

endpackage

// File: rtl/rrf_read_port.sv
// One operand lookup: picks array value, commit bypass, or pending ROB tag.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; outputs are valid whenever valid_i is high.
module rrf_read_port
  import rename_reg_file_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ROB_LOG = ROB_LOG_DEF
) (
  input  logic               valid_i,
  input  logic               idx_zero_i,
  input  logic [XLEN-1:0]    reg_value_i,
  input  logic [ROB_LOG-1:0] reg_tag_i,
  input  logic               reg_busy_i,
  input  logic               commit_valid_i,
  input  logic [ROB_LOG-1:0] commit_tag_i,
  input  logic [XLEN-1:0]    commit_value_i,
  output logic               ready_o,
  output logic [XLEN-1:0]    value_o,
  output logic [ROB_LOG-1:0] tag_o
);

  rd_src_e src;

  // Classify the lookup; x0 is never renamed so it always reads the array.
  always_comb begin
    src = SRC_NONE;
    if (!valid_i) begin
      src = SRC_NONE;
    end else if (idx_zero_i || !reg_busy_i) begin
      src = SRC_ARRAY;
    end else if (commit_valid_i && (commit_tag_i == reg_tag_i)) begin
      src = SRC_BYPASS;
    end else begin
      src = SRC_PENDING;
    end
  end

  // Drive every output in every case so nothing latches.
  always_comb begin
    ready_o = 1'b0;
    value_o = '0;
    tag_o   = '0;
    unique case (src)
      SRC_ARRAY: begin
        ready_o = 1'b1;
        value_o = idx_zero_i ? '0 : reg_value_i;
      end
      SRC_BYPASS: begin
        ready_o = 1'b1;
        value_o = commit_value_i;
      end
      SRC_PENDING: begin
        tag_o = reg_tag_i;
      end
      default: begin
        ready_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register ROB rename tags and busy bits.
// Latency: reads 0 cycles (with commit bypass); issue/commit/flush visible next cycle.
// Backpressure: none; rdy low freezes all state, reads still answer from held state.
module rename_reg_file
  import rename_reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int REG_LOG  = REG_LOG_DEF,
  parameter int ROB_LOG  = ROB_LOG_DEF,
  parameter int NUM_READ = NUM_READ_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic [NUM_READ-1:0]         rd_valid,
  input  logic [NUM_READ*REG_LOG-1:0] rd_idx,
  output logic [NUM_READ-1:0]         rd_ready,
  output logic [NUM_READ*XLEN-1:0]    rd_value,
  output logic [NUM_READ*ROB_LOG-1:0] rd_tag,
  input  logic                        issue_valid,
  input  logic [REG_LOG-1:0]          issue_dest,
  input  logic [ROB_LOG-1:0]          issue_tag,
  input  logic                        commit_valid,
  input  logic [REG_LOG-1:0]          commit_dest,
  input  logic [XLEN-1:0]             commit_value,
  input  logic [ROB_LOG-1:0]          commit_tag,
  input  logic                        flush
);

  localparam int NREG = 2 ** REG_LOG;

  logic [XLEN-1:0]    value_q [NREG];
  logic [XLEN-1:0]    value_d [NREG];
  logic [ROB_LOG-1:0] tag_q   [NREG];
  logic [ROB_LOG-1:0] tag_d   [NREG];
  logic [NREG-1:0]    busy_q;
  logic [NREG-1:0]    busy_d;

  logic commit_hit;
  logic issue_hit;

  assign commit_hit = commit_valid && (commit_dest != '0);
  assign issue_hit  = issue_valid && (issue_dest != '0) && !flush;

  // Next state: commit writes first, then flush or issue overrides the busy/tag.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    if (rdy) begin
      if (commit_hit) begin
        value_d[commit_dest] = commit_value;
        // Only the rename that produced this value may clear busy.
        if (busy_q[commit_dest] && (tag_q[commit_dest] == commit_tag)) begin
          busy_d[commit_dest] = 1'b0;
        end
      end
      if (flush) begin
        busy_d = '0;
      end else if (issue_hit) begin
        tag_d[issue_dest]  = issue_tag;
        busy_d[issue_dest] = 1'b1;
      end
    end
  end

  // State registers with synchronous reset that overrides rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
      end
      busy_q <= '0;
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

  // One independent lookup per read port, all against pre-update state.
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [REG_LOG-1:0] idx;
    assign idx = rd_idx[p*REG_LOG +: REG_LOG];

    rrf_read_port #(
      .XLEN    (XLEN),
      .ROB_LOG (ROB_LOG)
    ) u_port (
      .valid_i        (rd_valid[p]),
      .idx_zero_i     (idx == '0),
      .reg_value_i    (value_q[idx]),
      .reg_tag_i      (tag_q[idx]),
      .reg_busy_i     (busy_q[idx]),
      .commit_valid_i (commit_valid),
      .commit_tag_i   (commit_tag),
      .commit_value_i (commit_value),
      .ready_o        (rd_ready[p]),
      .value_o        (rd_value[p*XLEN +: XLEN]),
      .tag_o          (rd_tag[p*ROB_LOG +: ROB_LOG])
    );
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Self-checking bench for rename_reg_file: directed scenarios then random traffic.
// Expectations come from a register-level model of rename/commit/flush rules.
// Four read ports are built to show port independence.
module tb_rename_reg_file;

  localparam int XLEN    = 32;
  localparam int REG_LOG = 5;
  localparam int ROB_LOG = 4;
  localparam int NR      = 4;
  localparam int NREG    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, rdy;
  logic [NR-1:0]         rd_valid;
  logic [NR*REG_LOG-1:0] rd_idx;
  logic [NR-1:0]         rd_ready;
  logic [NR*XLEN-1:0]    rd_value;
  logic [NR*ROB_LOG-1:0] rd_tag;
  logic                  issue_valid;
  logic [REG_LOG-1:0]    issue_dest;
  logic [ROB_LOG-1:0]    issue_tag;
  logic                  commit_valid;
  logic [REG_LOG-1:0]    commit_dest;
  logic [XLEN-1:0]       commit_value;
  logic [ROB_LOG-1:0]    commit_tag;
  logic                  flush;

  rename_reg_file #(
    .XLEN(XLEN), .REG_LOG(REG_LOG), .ROB_LOG(ROB_LOG), .NUM_READ(NR)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rd_valid(rd_valid), .rd_idx(rd_idx),
    .rd_ready(rd_ready), .rd_value(rd_value), .rd_tag(rd_tag),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_tag(issue_tag),
    .commit_valid(commit_valid), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_tag(commit_tag),
    .flush(flush)
  );

  // Reference model: what each architectural register holds and who renames it.
  logic [XLEN-1:0]    m_val  [NREG];
  logic [ROB_LOG-1:0] m_tag  [NREG];
  bit                 m_busy [NREG];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    rd_valid = '0; rd_idx = '0;
    issue_valid = 1'b0; issue_dest = '0; issue_tag = '0;
    commit_valid = 1'b0; commit_dest = '0; commit_value = '0; commit_tag = '0;
  endtask

  task automatic set_rd(input int p, input int idx);
    rd_valid[p] = 1'b1;
    rd_idx[p*REG_LOG +: REG_LOG] = REG_LOG'(idx);
  endtask

  task automatic do_issue(input int d, input int t);
    issue_valid = 1'b1; issue_dest = REG_LOG'(d); issue_tag = ROB_LOG'(t);
  endtask

  task automatic do_commit(input int d, input int t, input logic [XLEN-1:0] v);
    commit_valid = 1'b1; commit_dest = REG_LOG'(d);
    commit_tag = ROB_LOG'(t); commit_value = v;
  endtask

  // Compare every port against what the model says a reader should see now.
  task automatic check_reads();
    for (int p = 0; p < NR; p++) begin
      int idx;
      logic er;
      logic [XLEN-1:0] ev;
      logic [ROB_LOG-1:0] et;
      idx = int'(rd_idx[p*REG_LOG +: REG_LOG]);
      er = 1'b0; ev = '0; et = '0;
      if (!rd_valid[p]) begin
        er = 1'b0;
      end else if (idx == 0) begin
        er = 1'b1;
      end else if (!m_busy[idx]) begin
        er = 1'b1; ev = m_val[idx];
      end else if (commit_valid && commit_tag == m_tag[idx]) begin
        er = 1'b1; ev = commit_value;
      end else begin
        et = m_tag[idx];
      end
      check_eq($sformatf("p%0d_x%0d_ready", p, idx), 64'(rd_ready[p]), 64'(er));
      check_eq($sformatf("p%0d_x%0d_value", p, idx), 64'(rd_value[p*XLEN +: XLEN]), 64'(ev));
      check_eq($sformatf("p%0d_x%0d_tag", p, idx), 64'(rd_tag[p*ROB_LOG +: ROB_LOG]), 64'(et));
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_val[r] = '0; m_tag[r] = '0; m_busy[r] = 1'b0;
      end
    end else if (rdy) begin
      if (commit_valid && commit_dest != 0) begin
        m_val[commit_dest] = commit_value;
        if (m_busy[commit_dest] && m_tag[commit_dest] == commit_tag)
          m_busy[commit_dest] = 1'b0;
      end
      if (flush) begin
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
      end else if (issue_valid && issue_dest != 0) begin
        m_tag[issue_dest]  = issue_tag;
        m_busy[issue_dest] = 1'b1;
      end
    end
  endtask

  task automatic step();
    #1;
    check_reads();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) begin
      m_val[r] = '0; m_tag[r] = '0; m_busy[r] = 1'b0;
    end
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model_edge();
    #1;
    idle();

    // Post-reset lookups.
    set_rd(0, 5); set_rd(1, 0); set_rd(2, 5); set_rd(3, 0);
    #1;
    check_eq("rst_x5_ready", 64'(rd_ready[0]), 64'd1);
    check_eq("rst_x5_value", 64'(rd_value[0 +: XLEN]), 64'd0);
    check_eq("rst_x0_ready", 64'(rd_ready[1]), 64'd1);
    check_eq("rst_x0_tag", 64'(rd_tag[ROB_LOG +: ROB_LOG]), 64'd0);
    step();

    // Rename x3, then retire it with a same-cycle reader.
    idle(); do_issue(3, 4); set_rd(0, 3); step();
    idle(); set_rd(0, 3); #1;
    check_eq("x3_pending_ready", 64'(rd_ready[0]), 64'd0);
    check_eq("x3_pending_tag", 64'(rd_tag[0 +: ROB_LOG]), 64'd4);
    step();
    idle(); do_commit(3, 4, 32'hDEAD); set_rd(0, 3); #1;
    check_eq("x3_bypass_ready", 64'(rd_ready[0]), 64'd1);
    check_eq("x3_bypass_value", 64'(rd_value[0 +: XLEN]), 64'hDEAD);
    step();
    idle(); set_rd(1, 3); #1;
    check_eq("x3_array_value", 64'(rd_value[XLEN +: XLEN]), 64'hDEAD);
    step();

    // Stale commit must not clear a newer rename.
    idle(); do_issue(7, 2); step();
    idle(); do_issue(7, 9); step();
    idle(); do_commit(7, 2, 32'd11); step();
    idle(); set_rd(2, 7); #1;
    check_eq("x7_stale_ready", 64'(rd_ready[2]), 64'd0);
    check_eq("x7_stale_tag", 64'(rd_tag[2*ROB_LOG +: ROB_LOG]), 64'd9);
    step();
    idle(); do_commit(7, 9, 32'd22); step();
    idle(); set_rd(3, 7); #1;
    check_eq("x7_final_value", 64'(rd_value[3*XLEN +: XLEN]), 64'd22);
    step();

    // Issue wins over a same-cycle commit to the same register.
    idle(); do_issue(4, 6); step();
    idle(); do_issue(4, 6); do_commit(4, 6, 32'd5); step();
    idle(); set_rd(0, 4); #1;
    check_eq("x4_reissue_ready", 64'(rd_ready[0]), 64'd0);
    check_eq("x4_reissue_tag", 64'(rd_tag[0 +: ROB_LOG]), 64'd6);
    step();

    // Flush clears renames, drops the same-cycle issue, keeps values.
    idle(); do_commit(9, 0, 32'h99); step();
    idle(); do_issue(1, 1); step();
    idle(); do_issue(2, 2); step();
    idle(); do_issue(9, 5); step();
    idle(); flush = 1'b1; do_issue(10, 3); step();
    idle(); set_rd(0, 1); set_rd(1, 2); set_rd(2, 9); set_rd(3, 10); #1;
    check_eq("flush_x10_ready", 64'(rd_ready[3]), 64'd1);
    check_eq("flush_x9_value", 64'(rd_value[2*XLEN +: XLEN]), 64'h99);
    check_eq("flush_all_ready", 64'(rd_ready), 64'hF);
    step();
    idle(); set_rd(0, 4); #1;
    check_eq("x4_array_value", 64'(rd_value[0 +: XLEN]), 64'd5);
    step();

    // rdy low freezes state.
    idle(); rdy = 1'b0; do_issue(5, 7); do_commit(9, 0, 32'h123); step();
    idle(); set_rd(0, 5); set_rd(1, 9); #1;
    check_eq("hold_x5_ready", 64'(rd_ready[0]), 64'd1);
    check_eq("hold_x9_value", 64'(rd_value[XLEN +: XLEN]), 64'h99);
    step();

    // x0 stays hardwired.
    idle(); do_issue(0, 1); do_commit(0, 1, 32'hFFFF); step();
    idle(); set_rd(0, 0); set_rd(3, 0); #1;
    check_eq("x0_value", 64'(rd_value[0 +: XLEN]), 64'd0);
    check_eq("x0_ready", 64'(rd_ready[3]), 64'd1);
    step();

    // Random traffic, commits biased toward the live rename so bypass/clear fire.
    for (int c = 0; c < 2000; c++) begin
      int cd;
      idle();
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) do_issue($urandom_range(0, NREG-1), $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        cd = $urandom_range(0, NREG-1);
        if ($urandom_range(0, 3) == 0)
          do_commit(cd, $urandom_range(0, 15), $urandom);
        else
          do_commit(cd, int'(m_tag[cd]), $urandom);
      end
      for (int p = 0; p < NR; p++) begin
        if ($urandom_range(0, 4) != 0) set_rd(p, $urandom_range(0, NREG-1));
        else rd_idx[p*REG_LOG +: REG_LOG] = REG_LOG'($urandom_range(0, NREG-1));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
